// File: rtl/sobel_line_feeder_if.sv
// Pixel-stream and tap bus between an upstream raster source and sobel_line_feeder.
// A beat moves when valid && ready on the same rising edge; done/frame_done are unacknowledged strobes.
interface sobel_line_feeder_if;
    logic [7:0] pixel;
    logic       valid;
    logic       ready;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    logic       done;
    logic       frame_done;
    logic [1:0] state;

    modport master (
        output pixel, valid,
        input  ready, d0, d1, d2, done, frame_done, state
    );

    modport slave (
        input  pixel, valid,
        output ready, d0, d1, d2, done, frame_done, state
    );
endinterface

// File: rtl/sobel_line_feeder.sv
// Two-line ping-pong buffer that turns a raster pixel stream into 3-row vertical taps.
// Define SOBEL_FEEDER_REPLICATE_EN for edge replication instead of zero padding at the borders.
module sobel_line_feeder #(
    parameter int ROWS = 480,
    parameter int COLS = 640
) (
    input  logic               clk,
    input  logic               rst,
    sobel_line_feeder_if.slave bus
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    typedef enum logic [1:0] {PRIME, STREAM, FLUSH} state_t;

    state_t          state;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic            wsel;
    logic            ready;
    logic            done;
    logic            frame_done;
    logic [7:0]      d0, d1, d2;

    logic [7:0]      line_a [COLS];
    logic [7:0]      line_b [COLS];

    logic            beat;
    logic            col_last;
    logic            row_last;
    logic [7:0]      rd_centre;
    logic [7:0]      rd_old;
    logic [7:0]      top_pad;
    logic [7:0]      bot_pad;

    assign beat     = bus.valid && ready;
    assign col_last = (col == CW'(COLS - 1));
    assign row_last = (row == RW'(ROWS - 1));

    // wsel selects the array holding the oldest line; the other one holds the centre line.
    assign rd_centre = wsel ? line_a[col] : line_b[col];
    assign rd_old    = wsel ? line_b[col] : line_a[col];

`ifdef SOBEL_FEEDER_REPLICATE_EN
    assign top_pad = rd_centre;
    assign bot_pad = rd_centre;
`else
    assign top_pad = 8'd0;
    assign bot_pad = 8'd0;
`endif

    always_ff @(posedge clk) begin
        if (beat) begin
            if (wsel) line_b[col] <= bus.pixel;
            else      line_a[col] <= bus.pixel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PRIME;
            col        <= '0;
            row        <= '0;
            wsel       <= 1'b0;
            ready      <= 1'b1;
            done       <= 1'b0;
            frame_done <= 1'b0;
            d0         <= 8'd0;
            d1         <= 8'd0;
            d2         <= 8'd0;
        end else begin
            done       <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                PRIME: begin
                    if (beat) begin
                        if (col_last) begin
                            col   <= '0;
                            row   <= row + RW'(1);
                            wsel  <= ~wsel;
                            state <= STREAM;
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                STREAM: begin
                    if (beat) begin
                        d0   <= bus.pixel;
                        d1   <= rd_centre;
                        d2   <= (row == RW'(1)) ? top_pad : rd_old;
                        done <= 1'b1;
                        if (col_last) begin
                            col  <= '0;
                            wsel <= ~wsel;
                            if (row_last) begin
                                row   <= '0;
                                ready <= 1'b0;
                                state <= FLUSH;
                            end else begin
                                row <= row + RW'(1);
                            end
                        end else begin
                            col <= col + CW'(1);
                        end
                    end
                end
                FLUSH: begin
                    // Bottom border: the last two stored lines become centre and oldest taps.
                    d0   <= bot_pad;
                    d1   <= rd_centre;
                    d2   <= rd_old;
                    done <= 1'b1;
                    if (col_last) begin
                        col        <= '0;
                        row        <= '0;
                        wsel       <= 1'b0;
                        frame_done <= 1'b1;
                        ready      <= 1'b1;
                        state      <= PRIME;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                default: begin
                    state <= PRIME;
                    ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready      = ready;
    assign bus.done       = done;
    assign bus.frame_done = frame_done;
    assign bus.d0         = d0;
    assign bus.d1         = d1;
    assign bus.d2         = d2;
    assign bus.state      = state;
endmodule
